// File: rtl/ascon_pkg.sv
// ---------------------------------------------------------------------------
// ascon_pkg
// Types and constants shared across the Ascon job scheduler slice.
//   state_t : scheduler FSM encoding (also exposed on the debug state port)
//   IDX_W   : width of the serial load/drain bit index buses
// ---------------------------------------------------------------------------
package ascon_pkg;

    localparam int IDX_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/ascon_rr_arb2.sv
// ---------------------------------------------------------------------------
// ascon_rr_arb2
// Two-way round-robin arbiter between the encrypt and decrypt requesters.
// When both request, the one that did not win the previous accepted grant
// wins. After reset the decrypt side counts as the last winner, so encrypt
// is preferred first.
//   clk, rst          : clock, synchronous active-high reset
//   req_enc, req_dec  : request levels
//   accept            : the grant offered this cycle is being taken
//   gnt_enc, gnt_dec  : combinational one-hot grant offer (zero if no request)
// ---------------------------------------------------------------------------
module ascon_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_enc,
    input  logic req_dec,
    input  logic accept,
    output logic gnt_enc,
    output logic gnt_dec
);

    logic last_dec;

    always_comb begin
        gnt_enc = req_enc && (!req_dec || last_dec);
        gnt_dec = req_dec && (!req_enc || !last_dec);
    end

    // The history moves when the grant is taken; every taken grant ends in
    // either DONE or ERR, so this matches updating at job end.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dec <= 1'b1;
        end else if (accept) begin
            last_dec <= gnt_dec;
        end
    end

endmodule

// File: rtl/ascon_job_scheduler.sv
// ---------------------------------------------------------------------------
// ascon_job_scheduler
// Shares one Ascon core between an encrypt and a decrypt requester. A job
// runs CLEAR (core reset pulse) -> LOAD (serial load window) -> START (wait
// for core ready, bounded by TIMEOUT) -> DRAIN (serial output window) ->
// DONE, or START -> ERR on timeout. Every output is a register.
//
// Handshakes:
//   enc_req/dec_req are levels; a request is taken only in IDLE, and the
//   one-hot grant then stays fixed until IDLE is re-entered regardless of
//   what the requester does. core_*_start is a level held from START entry
//   until DONE/ERR; only the ready of the granted direction is looked at,
//   and a ready sampled at 1 in START is the core's acceptance.
//
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   enc_req, dec_req                : job requests
//   grant_enc, grant_dec            : one-hot grant for the running job
//   core_rst                        : one-cycle core reset (CLEAR and ERR)
//   load_en, load_idx               : serial load window and bit index
//   core_enc_start, core_dec_start  : start level to the core
//   core_enc_ready, core_dec_ready  : core ready per direction
//   core_auth                       : core tag-check result
//   out_en, out_idx                 : serial drain window and bit index
//   done, done_auth                 : job completion pulse and auth result
//   busy                            : high in every state except IDLE
//   timeout_err                     : core-ready timeout pulse
//   state_dbg                       : current FSM state
// ---------------------------------------------------------------------------
module ascon_job_scheduler
    import ascon_pkg::*;
#(
    parameter int LOAD_BITS = 128,
    parameter int OUT_BITS  = 128,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_req,
    input  logic             dec_req,
    output logic             grant_enc,
    output logic             grant_dec,
    output logic             core_rst,
    output logic             load_en,
    output logic [IDX_W-1:0] load_idx,
    output logic             core_enc_start,
    output logic             core_dec_start,
    input  logic             core_enc_ready,
    input  logic             core_dec_ready,
    input  logic             core_auth,
    output logic             out_en,
    output logic [IDX_W-1:0] out_idx,
    output logic             done,
    output logic             done_auth,
    output logic             busy,
    output logic             timeout_err,
    output state_t           state_dbg
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              auth_q;
    logic              arb_enc;
    logic              arb_dec;
    logic              arb_accept;
    logic              ready_sel;

    assign arb_accept = (state == IDLE) && (enc_req || dec_req);

    // Ready of the direction that is not granted never matters.
    assign ready_sel = (grant_enc && core_enc_ready) || (grant_dec && core_dec_ready);

    assign state_dbg = state;

    ascon_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_enc (enc_req),
        .req_dec (dec_req),
        .accept  (arb_accept),
        .gnt_enc (arb_enc),
        .gnt_dec (arb_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            auth_q         <= 1'b0;
            grant_enc      <= 1'b0;
            grant_dec      <= 1'b0;
            core_rst       <= 1'b0;
            load_en        <= 1'b0;
            load_idx       <= '0;
            core_enc_start <= 1'b0;
            core_dec_start <= 1'b0;
            out_en         <= 1'b0;
            out_idx        <= '0;
            done           <= 1'b0;
            done_auth      <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            // Single-cycle pulses fall unless a transition below raises them.
            core_rst    <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (enc_req || dec_req) begin
                        state     <= CLEAR;
                        grant_enc <= arb_enc;
                        grant_dec <= arb_dec;
                        core_rst  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                CLEAR: begin
                    state    <= LOAD;
                    load_en  <= 1'b1;
                    load_idx <= '0;
                end

                // Index runs 0..LOAD_BITS inclusive: LOAD_BITS+1 cycles.
                LOAD: begin
                    if (load_idx == IDX_W'(LOAD_BITS)) begin
                        state          <= START;
                        load_en        <= 1'b0;
                        load_idx       <= '0;
                        core_enc_start <= grant_enc;
                        core_dec_start <= grant_dec;
                        wait_cnt       <= '0;
                    end else begin
                        load_idx <= load_idx + IDX_W'(1);
                    end
                end

                // wait_cnt holds the number of START cycles already spent, so
                // the ERR cycle lands exactly TIMEOUT cycles after START entry.
                START: begin
                    if (ready_sel) begin
                        state    <= DRAIN;
                        out_en   <= 1'b1;
                        out_idx  <= '0;
                        auth_q   <= core_auth;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        state          <= ERR;
                        timeout_err    <= 1'b1;
                        core_rst       <= 1'b1;
                        core_enc_start <= 1'b0;
                        core_dec_start <= 1'b0;
                        wait_cnt       <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                DRAIN: begin
                    if (out_idx == IDX_W'(OUT_BITS - 1)) begin
                        state          <= DONE;
                        out_en         <= 1'b0;
                        out_idx        <= '0;
                        core_enc_start <= 1'b0;
                        core_dec_start <= 1'b0;
                        done           <= 1'b1;
                        // Encryption has no tag to verify, so it always passes.
                        done_auth      <= grant_dec ? auth_q : 1'b1;
                    end else begin
                        out_idx <= out_idx + IDX_W'(1);
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    done_auth <= 1'b0;
                    busy      <= 1'b0;
                    grant_enc <= 1'b0;
                    grant_dec <= 1'b0;
                end

                ERR: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    grant_enc <= 1'b0;
                    grant_dec <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ascon_job_scheduler
// Directed bench for ascon_job_scheduler with LOAD_BITS=4, OUT_BITS=4,
// TIMEOUT=8. Inputs change 1 ns after a rising edge; outputs are read at the
// same point, i.e. they show the registers loaded by that edge.
// ---------------------------------------------------------------------------
module tb_ascon_job_scheduler;
    import ascon_pkg::*;

    localparam int LB = 4;
    localparam int OB = 4;
    localparam int TO = 8;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             enc_req = 1'b0;
    logic             dec_req = 1'b0;
    logic             core_enc_ready = 1'b0;
    logic             core_dec_ready = 1'b0;
    logic             core_auth = 1'b0;
    logic             grant_enc, grant_dec, core_rst, load_en;
    logic [IDX_W-1:0] load_idx, out_idx;
    logic             core_enc_start, core_dec_start, out_en;
    logic             done, done_auth, busy, timeout_err;
    state_t           state_dbg;

    ascon_job_scheduler #(
        .LOAD_BITS (LB),
        .OUT_BITS  (OB),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enc_req        (enc_req),
        .dec_req        (dec_req),
        .grant_enc      (grant_enc),
        .grant_dec      (grant_dec),
        .core_rst       (core_rst),
        .load_en        (load_en),
        .load_idx       (load_idx),
        .core_enc_start (core_enc_start),
        .core_dec_start (core_dec_start),
        .core_enc_ready (core_enc_ready),
        .core_dec_ready (core_dec_ready),
        .core_auth      (core_auth),
        .out_en         (out_en),
        .out_idx        (out_idx),
        .done           (done),
        .done_auth      (done_auth),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int               n_checks = 0;
    int               n_errors = 0;
    logic [IDX_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({grant_enc, grant_dec, core_rst, load_en, load_idx, core_enc_start,
                    core_dec_start, out_en, out_idx, done, done_auth, busy, timeout_err});
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        check("reset_outputs", all_outs(), 0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
    endtask

    // Requests must already be driven with the DUT in IDLE. Ends on the
    // START entry cycle.
    task automatic to_start(input bit dec, input bit keep_req);
        tick();
        check("clear_state", 32'(state_dbg), 32'(CLEAR));
        check("clear_core_rst", 32'(core_rst), 1);
        check("clear_grant", 32'({grant_enc, grant_dec}), dec ? 1 : 2);
        check("clear_busy", 32'(busy), 1);
        if (!keep_req) begin
            enc_req = 1'b0;
            dec_req = 1'b0;
        end
        for (int i = 0; i <= LB; i++) begin
            tick();
            check("load_en", 32'(load_en), 1);
            check("load_idx", 32'(load_idx), i);
            check("load_core_rst", 32'(core_rst), 0);
        end
        tick();
        check("start_state", 32'(state_dbg), 32'(START));
        check("start_load_en", 32'(load_en), 0);
        check("start_level", 32'({core_enc_start, core_dec_start}), dec ? 1 : 2);
        check("start_grant", 32'({grant_enc, grant_dec}), dec ? 1 : 2);
    endtask

    // Full job: ready of the granted direction is sampled at the end of the
    // ready_delay-th START cycle. With wrong=1 the other direction's ready is
    // high throughout START.
    task automatic run_job(input bit dec, input int ready_delay, input bit auth,
                           input bit keep_req, input bit wrong);
        to_start(dec, keep_req);
        for (int k = 0; k < ready_delay; k++) begin
            if (k > 0) begin
                tick();
                check("wait_state", 32'(state_dbg), 32'(START));
                check("wait_level", 32'({core_enc_start, core_dec_start}), dec ? 1 : 2);
            end
            if (wrong) begin
                if (dec) core_enc_ready = 1'b1;
                else     core_dec_ready = 1'b1;
            end
            if (k == ready_delay - 1) begin
                if (dec) core_dec_ready = 1'b1;
                else     core_enc_ready = 1'b1;
                core_auth = auth;
            end
        end
        for (int j = 0; j < OB; j++) exp_q.push_back(IDX_W'(j));
        for (int j = 0; j < OB; j++) begin
            tick();
            if (j == 0) begin
                core_enc_ready = 1'b0;
                core_dec_ready = 1'b0;
            end
            if (j == 1) core_auth = ~auth;
            check("drain_state", 32'(state_dbg), 32'(DRAIN));
            check("drain_out_en", 32'(out_en), 1);
            check("drain_out_idx", 32'(out_idx), 32'(exp_q.pop_front()));
            check("drain_level", 32'({core_enc_start, core_dec_start}), dec ? 1 : 2);
        end
        tick();
        core_auth = 1'b0;
        check("done_state", 32'(state_dbg), 32'(DONE));
        check("done_pulse", 32'(done), 1);
        check("done_auth", 32'(done_auth), dec ? 32'(auth) : 1);
        check("done_level", 32'({core_enc_start, core_dec_start}), 0);
        check("done_out_en", 32'(out_en), 0);
        check("done_busy", 32'(busy), 1);
        check("done_grant", 32'({grant_enc, grant_dec}), dec ? 1 : 2);
        tick();
        check("idle_state", 32'(state_dbg), 32'(IDLE));
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("idle_grant", 32'({grant_enc, grant_dec}), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // Lone encrypt job: 5 load cycles, ready after 3 START cycles.
        enc_req = 1'b1;
        run_job(1'b0, 3, 1'b0, 1'b0, 1'b0);

        // Both requests from reset: enc first, then dec back to back.
        do_reset();
        enc_req = 1'b1;
        dec_req = 1'b1;
        run_job(1'b0, 2, 1'b1, 1'b1, 1'b0);
        run_job(1'b1, 2, 1'b0, 1'b0, 1'b0);

        // Decrypt with passing tag; enc ready held high while waiting.
        dec_req = 1'b1;
        run_job(1'b1, 3, 1'b1, 1'b0, 1'b1);

        // Timeout: ready never arrives.
        enc_req = 1'b1;
        to_start(1'b0, 1'b0);
        for (int k = 1; k < TO; k++) begin
            tick();
            check("to_wait_state", 32'(state_dbg), 32'(START));
            check("to_no_err_yet", 32'(timeout_err), 0);
        end
        tick();
        check("to_err_state", 32'(state_dbg), 32'(ERR));
        check("to_err_pulse", 32'(timeout_err), 1);
        check("to_core_rst", 32'(core_rst), 1);
        check("to_no_done", 32'(done), 0);
        check("to_level_off", 32'({core_enc_start, core_dec_start}), 0);
        check("to_busy", 32'(busy), 1);
        tick();
        check("to_idle_state", 32'(state_dbg), 32'(IDLE));
        check("to_idle_busy", 32'(busy), 0);
        check("to_idle_err", 32'(timeout_err), 0);
        check("to_idle_core_rst", 32'(core_rst), 0);

        // Timed-out enc job counts as the last grant, so dec wins next.
        enc_req = 1'b1;
        dec_req = 1'b1;
        run_job(1'b1, 1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of DRAIN, with a request present on the reset edge.
        enc_req = 1'b1;
        to_start(1'b0, 1'b0);
        core_enc_ready = 1'b1;
        tick();
        core_enc_ready = 1'b0;
        check("mid_drain_idx0", 32'(out_idx), 0);
        tick();
        check("mid_drain_idx1", 32'(out_idx), 1);
        rst = 1'b1;
        enc_req = 1'b1;
        tick();
        check("mid_rst_outputs", all_outs(), 0);
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        dec_req = 1'b1;
        run_job(1'b0, 2, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule

// File: doc/ascon_job_scheduler.md
ASCON_JOB_SCHEDULER -- requirements
Module: ascon_job_scheduler

Interface
REQ-001 SHALL have parameter LOAD_BITS, default 128, serial input cycles per job (max operand width; 1..255).
REQ-002 SHALL have parameter OUT_BITS, default 128, serial output cycles per job (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles waited for core ready (>=2).
REQ-004 SHALL have port clk in 1, rising-edge clock.
REQ-005 SHALL have port rst in 1, synchronous, active-high reset.
REQ-006 SHALL have ports enc_req, dec_req in 1 each, level job requests from two requesters.
REQ-007 SHALL have ports grant_enc, grant_dec out 1 each, registered one-hot grant held for the whole job.
REQ-008 SHALL have port core_rst out 1, one-cycle synchronous reset pulse to the shared Ascon core.
REQ-009 SHALL have ports load_en out 1 and load_idx out 8, serial-load window and bit index.
REQ-010 SHALL have ports core_enc_start, core_dec_start out 1 each, level start to the core.
REQ-011 SHALL have ports core_enc_ready, core_dec_ready, core_auth in 1 each, core status.
REQ-012 SHALL have ports out_en out 1 and out_idx out 8, serial-drain window and bit index.
REQ-013 SHALL have ports done, done_auth, busy, timeout_err out 1 each.

Function
REQ-014 SHALL implement states IDLE, CLEAR, LOAD, START, DRAIN, DONE, ERR; all outputs registered.
REQ-015 IDLE: busy=0; on any request, grant one requester and go to CLEAR next cycle.
REQ-016 Arbitration: single request wins; both pending -> requester not granted last; after reset, enc preferred.
REQ-017 Grant latched at IDLE exit, kept until IDLE re-entered; request deassertion mid-job ignored.
REQ-018 CLEAR: core_rst=1 exactly one cycle, then LOAD.
REQ-019 LOAD: load_en=1 for LOAD_BITS+1 consecutive cycles, load_idx 0..LOAD_BITS, then START.
REQ-020 START: core_enc_start or core_dec_start (per grant) held high until matching core ready sampled 1, then DRAIN.
REQ-021 START: wait counter increments per cycle; reaching TIMEOUT with ready still 0 -> ERR.
REQ-022 Ready of the non-granted direction SHALL be ignored.
REQ-023 DRAIN: start stays high; out_en=1 for OUT_BITS cycles, out_idx 0..OUT_BITS-1, then DONE.
REQ-024 core_auth SHALL be sampled on the DRAIN entry cycle; done_auth = sample for dec jobs, 1 for enc jobs.
REQ-025 DONE: done=1 one cycle, start deasserted, done_auth valid same cycle; then IDLE.
REQ-026 ERR: timeout_err=1 and core_rst=1 one cycle, no done; then IDLE; last-grant updated as if job completed.
REQ-027 busy=1 in every state except IDLE.
REQ-028 Request arriving in DONE/ERR SHALL be served no earlier than first IDLE cycle after.

Reset
REQ-029 rst SHALL force IDLE, last-grant=dec (so enc preferred), all counters 0, all outputs 0, from any state incl. mid-LOAD/DRAIN.
REQ-030 rst SHALL have priority over every transition in the same cycle.

Structure
REQ-031 State encoding and index width (8) SHALL live in shared package ascon_pkg.
REQ-032 Round-robin two-way arbiter SHALL be sub-module ascon_rr_arb2; FSM and counters in top.

Verification
REQ-033 enc_req alone, LOAD_BITS=4, OUT_BITS=4, ready after 3 cycles -> CLEAR 1, load_en 5 cycles, out_en 4 cycles, done=1, done_auth=1.
REQ-034 enc_req and dec_req together from reset -> grant_enc first job; both held -> grant_dec second job.
REQ-035 dec job, core_auth=0 at ready -> done=1, done_auth=0; with core_auth=1 -> done_auth=1.
REQ-036 TIMEOUT=8, ready never asserted -> timeout_err and core_rst pulse 8 cycles after START entry, no done, busy=0 next cycle.
REQ-037 rst asserted mid-DRAIN -> next cycle all outputs 0, IDLE; following enc_req restarts at CLEAR.
REQ-038 grant_dec job, core_enc_ready pulsed high -> ignored, scheduler remains in START.
